// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared core types and constants.
//            Holds the branch opcode enum and the sequential PC increment.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Branch opcodes, encoded with the RISC-V funct3 values. Codes 010 and 011
  // are intentionally absent; they are illegal.
  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_op_t;

  // Fall-through distance for a not-taken branch.
  localparam logic [31:0] PC_INC = 32'd4;

endpackage
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ============================================================================
// Module   : branch_cmp
// Brief    : Combinational branch comparator. Derives the flags from
//            rs1 - rs2 and selects the branch condition.
// Revision : 1.0 - initial release
// ============================================================================
module branch_cmp
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_op,
  output logic            o_taken
);

  logic [XLEN:0] w_diff;
  logic          w_zero;
  logic          w_neg;
  logic          w_ovf;
  logic          w_borrow;
  logic          w_lt_s;
  logic          w_lt_u;

  // The extra top bit of the subtraction is the unsigned borrow.
  assign w_diff   = {1'b0, i_rs1} - {1'b0, i_rs2};
  assign w_zero   = (w_diff[XLEN-1:0] == '0);
  assign w_neg    = w_diff[XLEN-1];
  assign w_borrow = w_diff[XLEN];
  assign w_ovf    = (i_rs1[XLEN-1] != i_rs2[XLEN-1]) && (w_diff[XLEN-1] != i_rs1[XLEN-1]);
  assign w_lt_s   = w_neg ^ w_ovf;
  assign w_lt_u   = w_borrow;

  // Condition select; illegal opcodes resolve not-taken.
  always_comb begin
    o_taken = 1'b0;
    case (i_op)
      BEQ:     o_taken = w_zero;
      BNE:     o_taken = !w_zero;
      BLT:     o_taken = w_lt_s;
      BGE:     o_taken = !w_lt_s;
      BLTU:    o_taken = w_lt_u;
      BGEU:    o_taken = !w_lt_u;
      default: o_taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Brief    : Two-stage branch resolution unit. S1 captures the issued
//            branch, S2 holds the resolved direction, next PC and
//            mispredict flag. Valid/ready on both sides, with flush.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit
  import core_pkg::*;
#(
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_op_i,
  input  logic [XLEN-1:0]  in_rs1_i,
  input  logic [XLEN-1:0]  in_rs2_i,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic [XLEN-1:0]  in_imm_i,
  input  logic             in_pred_taken_i,
  input  logic [XLEN-1:0]  in_pred_target_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_taken_o,
  output logic [XLEN-1:0]  out_next_pc_o,
  output logic             out_mispredict_o,
  output logic [TAG_W-1:0] out_tag_o
);

  // S1: captured issue
  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [XLEN-1:0]  r_s1_rs1;
  logic [XLEN-1:0]  r_s1_rs2;
  logic [XLEN-1:0]  r_s1_pc;
  logic [XLEN-1:0]  r_s1_imm;
  logic             r_s1_pred_taken;
  logic [XLEN-1:0]  r_s1_pred_target;
  logic [TAG_W-1:0] r_s1_tag;

  // S2: resolution
  logic             r_s2_valid;
  logic             r_s2_taken;
  logic [XLEN-1:0]  r_s2_next_pc;
  logic             r_s2_mispredict;
  logic [TAG_W-1:0] r_s2_tag;

  logic             w_s2_free;
  logic             w_s1_advance;
  logic             w_in_fire;
  logic             w_taken;
  logic [XLEN-1:0]  w_next_pc;
  logic             w_mispredict;

  // S2 can take a new entry when it is empty or being drained this cycle.
  assign w_s2_free    = !r_s2_valid || out_ready_i;
  assign w_s1_advance = r_s1_valid && w_s2_free;
  assign in_ready_o   = !r_s1_valid || w_s1_advance;
  assign w_in_fire    = in_valid_i && in_ready_o;

  branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .i_rs1   (r_s1_rs1),
    .i_rs2   (r_s1_rs2),
    .i_op    (r_s1_op),
    .o_taken (w_taken)
  );

  assign w_next_pc    = r_s1_pc + (w_taken ? r_s1_imm : PC_INC[XLEN-1:0]);
  assign w_mispredict = (w_taken != r_s1_pred_taken) || (w_next_pc != r_s1_pred_target);

  // Stage valids: async reset, flush kills both stages and any concurrent issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (in_ready_o) r_s1_valid <= in_valid_i;
      if (w_s2_free)  r_s2_valid <= r_s1_valid;
    end
  end

  // S1 payload capture on an accepted issue; contents are don't-care when invalid.
  always_ff @(posedge clk_i) begin
    if (w_in_fire) begin
      r_s1_op          <= in_op_i;
      r_s1_rs1         <= in_rs1_i;
      r_s1_rs2         <= in_rs2_i;
      r_s1_pc          <= in_pc_i;
      r_s1_imm         <= in_imm_i;
      r_s1_pred_taken  <= in_pred_taken_i;
      r_s1_pred_target <= in_pred_target_i;
      r_s1_tag         <= in_tag_i;
    end
  end

  // S2 payload loads only when S1 advances, so it stays frozen while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_taken      <= 1'b0;
      r_s2_next_pc    <= '0;
      r_s2_mispredict <= 1'b0;
      r_s2_tag        <= '0;
    end else if (w_s1_advance) begin
      r_s2_taken      <= w_taken;
      r_s2_next_pc    <= w_next_pc;
      r_s2_mispredict <= w_mispredict;
      r_s2_tag        <= r_s1_tag;
    end
  end

  assign out_valid_o      = r_s2_valid;
  assign out_taken_o      = r_s2_taken;
  assign out_next_pc_o    = r_s2_next_pc;
  assign out_mispredict_o = r_s2_mispredict;
  assign out_tag_o        = r_s2_tag;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_unit
// Brief    : Self-checking bench for branch_unit: directed vector table,
//            multi-cycle sequences and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  in_op_i = 3'd0;
  logic [31:0] in_rs1_i = '0;
  logic [31:0] in_rs2_i = '0;
  logic [31:0] in_pc_i = '0;
  logic [31:0] in_imm_i = '0;
  logic        in_pred_taken_i = 1'b0;
  logic [31:0] in_pred_target_i = '0;
  logic [5:0]  in_tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        out_taken_o;
  logic [31:0] out_next_pc_o;
  logic        out_mispredict_o;
  logic [5:0]  out_tag_o;

  branch_unit #(.TAG_W(6), .XLEN(32)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_op_i          (in_op_i),
    .in_rs1_i         (in_rs1_i),
    .in_rs2_i         (in_rs2_i),
    .in_pc_i          (in_pc_i),
    .in_imm_i         (in_imm_i),
    .in_pred_taken_i  (in_pred_taken_i),
    .in_pred_target_i (in_pred_target_i),
    .in_tag_i         (in_tag_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_taken_o      (out_taken_o),
    .out_next_pc_o    (out_next_pc_o),
    .out_mispredict_o (out_mispredict_o),
    .out_tag_o        (out_tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        taken;
    logic [31:0] next_pc;
    logic        mis;
    logic [5:0]  tag;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptgt;
    logic [5:0]  tag;
    logic        e_taken;
    logic [31:0] e_next;
    logic        e_mis;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  res_t q[$];
  logic [5:0] dtags[$];
  logic hold_pending = 1'b0;
  res_t held;
  logic accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: branch semantics stated directly as signed/unsigned compares.
  function automatic res_t model(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                                 input logic [31:0] ptgt, input logic [5:0] tag);
    res_t r;
    case (op)
      3'd0:    r.taken = (rs1 == rs2);
      3'd1:    r.taken = (rs1 != rs2);
      3'd4:    r.taken = ($signed(rs1) <  $signed(rs2));
      3'd5:    r.taken = ($signed(rs1) >= $signed(rs2));
      3'd6:    r.taken = (rs1 <  rs2);
      3'd7:    r.taken = (rs1 >= rs2);
      default: r.taken = 1'b0;
    endcase
    r.next_pc = r.taken ? pc + imm : pc + 32'd4;
    r.mis     = (r.taken != pt) || (r.next_pc != ptgt);
    r.tag     = tag;
    return r;
  endfunction

  task automatic rand_issue(input logic [5:0] tag);
    logic [31:0] x;
    in_op_i  = 3'($urandom_range(0, 7));
    in_rs1_i = $urandom;
    case ($urandom_range(0, 3))
      0:       in_rs2_i = in_rs1_i;
      1:       begin in_rs1_i = 32'h8000_0000; in_rs2_i = 32'h7FFF_FFFF; end
      default: in_rs2_i = $urandom;
    endcase
    in_pc_i  = $urandom & 32'hFFFF_FFFC;
    x        = $urandom;
    in_imm_i = {{19{x[12]}}, x[12:1], 1'b0};
    in_pred_taken_i = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 2))
      0:       in_pred_target_i = in_pc_i + 32'd4;
      1:       in_pred_target_i = in_pc_i + in_imm_i;
      default: in_pred_target_i = $urandom;
    endcase
    in_tag_i = tag;
  endtask

  // One clock of scoreboarded traffic; called at a negedge with inputs applied.
  task automatic tick();
    res_t e;
    #1;
    if (hold_pending) begin
      check("hold_valid", out_valid_o, 1);
      if (out_valid_o) begin
        check("hold_tag", out_tag_o, held.tag);
        check("hold_taken", out_taken_o, held.taken);
        check("hold_next_pc", out_next_pc_o, held.next_pc);
        check("hold_mis", out_mispredict_o, held.mis);
      end
    end
    if (out_valid_o && out_ready_i) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_out: got tag 0x%02h required no output", out_tag_o);
      end else begin
        e = q.pop_front();
        check("out_tag", out_tag_o, e.tag);
        check("out_taken", out_taken_o, e.taken);
        check("out_next_pc", out_next_pc_o, e.next_pc);
        check("out_mis", out_mispredict_o, e.mis);
        dtags.push_back(out_tag_o);
      end
    end
    hold_pending = out_valid_o && !out_ready_i;
    held.tag = out_tag_o; held.taken = out_taken_o;
    held.next_pc = out_next_pc_o; held.mis = out_mispredict_o;
    accepted = in_valid_i && in_ready_o;
    if (accepted && !flush_i)
      q.push_back(model(in_op_i, in_rs1_i, in_rs2_i, in_pc_i, in_imm_i,
                        in_pred_taken_i, in_pred_target_i, in_tag_i));
    if (flush_i) begin
      q.delete();
      hold_pending = 1'b0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                op      rs1           rs2           pc            imm           pt    ptgt          tag    taken next_pc       mis
    vecs[0] = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000100, 32'h00000020, 1'b0, 32'h00000104, 6'd1, 1'b1, 32'h00000120, 1'b1};
    vecs[1] = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000100, 32'h00000020, 1'b0, 32'h00000104, 6'd2, 1'b0, 32'h00000104, 1'b0};
    vecs[2] = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000200, 32'h00000040, 1'b0, 32'h00000204, 6'd3, 1'b0, 32'h00000204, 1'b0};
    vecs[3] = '{3'b000, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000100, 32'h00000040, 1'b1, 32'h00000120, 6'd4, 1'b1, 32'h00000140, 1'b1};
    vecs[4] = '{3'b001, 32'h00000007, 32'h00000007, 32'hFFFFFFFC, 32'h00000008, 1'b0, 32'h00000000, 6'd5, 1'b0, 32'h00000000, 1'b0};
    vecs[5] = '{3'b010, 32'h00000001, 32'h00000001, 32'h00000300, 32'h00000010, 1'b1, 32'h00000310, 6'd6, 1'b0, 32'h00000304, 1'b1};
    vecs[6] = '{3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFF0, 1'b0, 32'h00000004, 6'd7, 1'b0, 32'h00000004, 1'b0};
    vecs[7] = '{3'b001, 32'h00000001, 32'h00000002, 32'h00001000, 32'hFFFFFFFC, 1'b1, 32'h00000FFC, 6'd8, 1'b1, 32'h00000FFC, 1'b0};

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_taken", out_taken_o, 0);
    check("rst_out_mis", out_mispredict_o, 0);
    check("rst_out_next_pc", out_next_pc_o, 0);
    check("rst_out_tag", out_tag_o, 0);
    rst_ni = 1'b1;
    #1 check("rst_in_ready", in_ready_o, 1);
    @(negedge clk_i);

    // Directed vectors, one at a time, checking the two-edge latency
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_op_i = vecs[i].op; in_rs1_i = vecs[i].rs1; in_rs2_i = vecs[i].rs2;
      in_pc_i = vecs[i].pc; in_imm_i = vecs[i].imm; in_pred_taken_i = vecs[i].pt;
      in_pred_target_i = vecs[i].ptgt; in_tag_i = vecs[i].tag;
      in_valid_i = 1'b1;
      #1 check("vec_in_ready", in_ready_o, 1);
      @(posedge clk_i);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      #1 check("vec_lat_n1_valid", out_valid_o, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      check("vec_lat_n2_valid", out_valid_o, 1);
      check("vec_tag", out_tag_o, vecs[i].tag);
      check("vec_taken", out_taken_o, vecs[i].e_taken);
      check("vec_next_pc", out_next_pc_o, vecs[i].e_next);
      check("vec_mis", out_mispredict_o, vecs[i].e_mis);
    end
    in_valid_i = 1'b0;
    @(negedge clk_i);

    // Backpressure: four back-to-back issues, consumer stalled for four cycles
    begin
      int ntag;
      ntag = 1;
      dtags.delete();
      for (int cyc = 0; cyc < 30 && (ntag <= 4 || q.size() > 0); cyc++) begin
        out_ready_i = (cyc >= 4);
        in_valid_i  = (ntag <= 4);
        rand_issue(6'(ntag));
        if (cyc == 2 || cyc == 3) begin
          #1 check("full_in_ready", in_ready_o, 0);
          check("full_out_valid", out_valid_o, 1);
        end
        tick();
        if (accepted) ntag++;
      end
      check("bp_drain_empty", q.size(), 0);
      check("bp_count", dtags.size(), 4);
      for (int k = 0; k < 4 && k < dtags.size(); k++)
        check("bp_order", dtags[k], k + 1);
    end
    in_valid_i = 1'b0;

    // Flush with both stages full and an issue presented
    out_ready_i = 1'b0;
    rand_issue(6'd10); in_valid_i = 1'b1; tick();
    rand_issue(6'd11); tick();
    rand_issue(6'd12); flush_i = 1'b1; tick();
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    #1 check("flush_out_valid", out_valid_o, 0);
    check("flush_in_ready", in_ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_quiet", out_valid_o, 0);
    end

    // Flush while an issue actually handshakes
    rand_issue(6'd20); in_valid_i = 1'b1; tick();
    rand_issue(6'd21); flush_i = 1'b1; tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush2_quiet", out_valid_o, 0);
    end

    // Asynchronous reset mid-stream
    in_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_issue(6'(30 + k));
      tick();
    end
    check("pre_rst_out_valid", out_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1 check("async_rst_out_valid", out_valid_o, 0);
    check("async_rst_in_ready", in_ready_o, 1);
    q.delete();
    hold_pending = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      rand_issue(6'($urandom_range(0, 63)));
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    check("rand_drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
